// File: rtl/add3_sched_pkg.sv
// Shared constants and helpers for the md5crypt 3-operand adder scheduler.
// Default sizing matches the md5crypt core (32-bit words, 4 thread slots).
package add3_sched_pkg;

  localparam int MD5_WIDTH = 32;
  localparam int MD5_N_REQ = 4;

  // Index visited at step k of a round-robin search that starts after ptr.
  function automatic int rr_idx(input int ptr, input int k, input int n);
    return (ptr + k) % n;
  endfunction

endpackage

// File: rtl/add3_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester after the last winner.
// The pointer only moves when the grant is actually taken (adv high).
module rr_arbiter
  import add3_sched_pkg::*;
#(
  parameter int N_REQ = MD5_N_REQ,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] valid,
  input  logic             adv,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  winner,
  output logic             any
);

  logic [ID_W-1:0] ptr;

  always_comb begin
    int idx;
    idx    = 0;
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = rr_idx(int'(ptr), k, N_REQ);
      if (!any && valid[idx]) begin
        any        = 1'b1;
        winner     = ID_W'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  // Valid winner plus downstream room means the transfer completes.
  always_ff @(posedge clk) begin
    if (reset)           ptr <= ID_W'(N_REQ - 1);
    else if (any && adv) ptr <= winner;
  end

endmodule

// File: rtl/add3_sched.sv
// Shares one a+b+c adder among N_REQ requesters with a tagged valid/ready result.
// Define ADD3_SCHED_PIPE_EN to split the adder into two stages (3-cycle latency).
module add3_sched
  import add3_sched_pkg::*;
#(
  parameter int N_REQ = MD5_N_REQ,
  parameter int WIDTH = MD5_WIDTH,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ*WIDTH-1:0] req_c,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH-1:0]       res_data,
  output logic [ID_W-1:0]        res_id
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [ID_W-1:0]  id;
  } op_t;

  logic [N_REQ-1:0][WIDTH-1:0] a_v, b_v, c_v;
  assign a_v = req_a;
  assign b_v = req_b;
  assign c_v = req_c;

  logic             adv1, adv2, any;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  winner;
  op_t              sel, s1;
  logic             v1, v2;
  logic [WIDTH-1:0] d2;
  logic [ID_W-1:0]  id2;

  // Next-state sources for S2, supplied by whichever adder layout is built.
  logic             s2_v;
  logic [WIDTH-1:0] s2_sum;
  logic [ID_W-1:0]  s2_id;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk    (CLK),
    .reset  (reset),
    .valid  (req_valid),
    .adv    (adv1),
    .grant  (grant),
    .winner (winner),
    .any    (any)
  );

  assign req_ready = grant & {N_REQ{adv1 & !reset}};

  always_comb begin
    sel.a  = a_v[winner];
    sel.b  = b_v[winner];
    sel.c  = c_v[winner];
    sel.id = winner;
  end

  assign adv2 = !v2 || res_ready;

`ifdef ADD3_SCHED_PIPE_EN
  logic             vb, advb;
  logic [WIDTH-1:0] ab_b, c_b;
  logic [ID_W-1:0]  id_b;

  assign advb = !vb || adv2;
  assign adv1 = !v1 || advb;

  always_ff @(posedge CLK) begin
    if (reset) begin
      vb   <= 1'b0;
      ab_b <= '0;
      c_b  <= '0;
      id_b <= '0;
    end else if (advb) begin
      vb   <= v1;
      ab_b <= s1.a + s1.b;
      c_b  <= s1.c;
      id_b <= s1.id;
    end
  end

  assign s2_v   = vb;
  assign s2_sum = ab_b + c_b;
  assign s2_id  = id_b;
`else
  assign adv1   = !v1 || adv2;
  assign s2_v   = v1;
  assign s2_sum = s1.a + s1.b + s1.c;
  assign s2_id  = s1.id;
`endif

  // S1: operand register, loads the granted request (or a bubble).
  always_ff @(posedge CLK) begin
    if (reset) begin
      v1 <= 1'b0;
      s1 <= '0;
    end else if (adv1) begin
      v1 <= any;
      s1 <= sel;
    end
  end

  // S2: result register; holds while the consumer stalls.
  always_ff @(posedge CLK) begin
    if (reset) begin
      v2  <= 1'b0;
      d2  <= '0;
      id2 <= '0;
    end else if (adv2) begin
      v2  <= s2_v;
      d2  <= s2_sum;
      id2 <= s2_id;
    end
  end

  assign res_valid = v2;
  assign res_data  = d2;
  assign res_id    = id2;

endmodule

// File: tb/tb_add3_sched.sv
// Directed bench for add3_sched (N_REQ=4, WIDTH=32), aware of ADD3_SCHED_PIPE_EN latency.
module tb_add3_sched;

`ifdef ADD3_SCHED_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic              CLK;
  logic              reset;
  logic [3:0]        req_valid;
  logic [3:0]        req_ready;
  logic [3:0][31:0]  a_v, b_v, c_v;
  logic              res_valid;
  logic              res_ready;
  logic [31:0]       res_data;
  logic [1:0]        res_id;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_sum [4];

  add3_sched #(.N_REQ(4), .WIDTH(32)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (a_v),
    .req_b     (b_v),
    .req_c     (c_v),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic load_table;
    for (int i = 0; i < 4; i++) begin
      a_v[i] = 32'h0100_0000 * (i + 1);
      b_v[i] = 32'h10 * i;
      c_v[i] = 32'h5;
    end
    exp_sum[0] = 32'h0100_0005;
    exp_sum[1] = 32'h0200_0015;
    exp_sum[2] = 32'h0300_0025;
    exp_sum[3] = 32'h0400_0035;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    req_valid = 4'hF;
    res_ready = 1'b1;
    load_table();
    step();
    step();
    @(negedge CLK);
    total++;
    if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", res_valid); end
    total++;
    if (res_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", res_data); end
    total++;
    if (res_id !== 2'd0) begin bad++; $display("FAIL reset_id got=%0d want=0", res_id); end
    total++;
    if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
    step();
    req_valid = 4'h0;
    reset     = 1'b0;
    step();
  endtask

  task automatic test_single_req(input int slot, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, input logic [31:0] exp_d);
    res_ready  = 1'b1;
    a_v[slot]  = a;
    b_v[slot]  = b;
    c_v[slot]  = c;
    req_valid  = 4'b0001 << slot;
    @(negedge CLK);
    total++;
    if (req_ready !== (4'b0001 << slot))
      begin bad++; $display("FAIL single_grant got=%b want=%b", req_ready, 4'b0001 << slot); end
    step();
    req_valid = 4'h0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge CLK);
      if (k < LAT) begin
        total++;
        if (res_valid !== 1'b0) begin bad++; $display("FAIL single_early cyc=%0d got=%b want=0", k, res_valid); end
      end else begin
        total++;
        if (res_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", res_valid); end
        total++;
        if (res_data !== exp_d) begin bad++; $display("FAIL single_data got=%h want=%h", res_data, exp_d); end
        total++;
        if (res_id !== 2'(slot)) begin bad++; $display("FAIL single_id got=%0d want=%0d", res_id, slot); end
      end
      step();
    end
    @(negedge CLK);
    total++;
    if (res_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b want=0", res_valid); end
    step();
  endtask

  task automatic test_round_robin;
    do_reset();
    load_table();
    res_ready = 1'b1;
    req_valid = 4'hF;
    for (int cyc = 0; cyc < 8 + LAT; cyc++) begin
      @(negedge CLK);
      if (cyc < 8) begin
        total++;
        if (req_ready !== (4'b0001 << (cyc % 4)))
          begin bad++; $display("FAIL rr_grant cyc=%0d got=%b want=%b", cyc, req_ready, 4'b0001 << (cyc % 4)); end
      end
      if (cyc >= LAT) begin
        total++;
        if (res_valid !== 1'b1 || res_id !== 2'((cyc - LAT) % 4) || res_data !== exp_sum[(cyc - LAT) % 4])
          begin bad++; $display("FAIL rr_result cyc=%0d got=%b/%0d/%h want=1/%0d/%h", cyc, res_valid, res_id,
                                res_data, (cyc - LAT) % 4, exp_sum[(cyc - LAT) % 4]); end
      end
      step();
      if (cyc == 7) req_valid = 4'h0;
    end
    step();
  endtask

  task automatic test_backpressure;
    int accepts;
    int n;
    logic [31:0] held;
    do_reset();
    load_table();
    res_ready = 1'b0;
    req_valid = 4'hF;
    accepts   = 0;
    held      = 32'h0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge CLK);
      accepts += $countones(req_valid & req_ready);
      if (cyc == LAT) held = res_data;
      step();
    end
    @(negedge CLK);
    total++;
    if (accepts != LAT) begin bad++; $display("FAIL bp_accepts got=%0d want=%0d", accepts, LAT); end
    total++;
    if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_stall_ready got=%b want=0000", req_ready); end
    total++;
    if (res_valid !== 1'b1 || res_data !== exp_sum[0] || held !== exp_sum[0])
      begin bad++; $display("FAIL bp_hold got=%b/%h first=%h want=1/%h", res_valid, res_data, held, exp_sum[0]); end
    step();
    res_ready = 1'b1;
    n         = 0;
    accepts   = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge CLK);
      if (cyc == 0) begin
        total++;
        if (req_ready !== (4'b0001 << LAT))
          begin bad++; $display("FAIL bp_resume got=%b want=%b", req_ready, 4'b0001 << LAT); end
      end
      accepts += $countones(req_valid & req_ready);
      if (res_valid && res_ready) begin
        total++;
        if (res_id !== 2'(n % 4) || res_data !== exp_sum[n % 4])
          begin bad++; $display("FAIL bp_order n=%0d got=%0d/%h want=%0d/%h", n, res_id, res_data, n % 4, exp_sum[n % 4]); end
        n++;
      end
      step();
    end
    total++;
    if (n != 8) begin bad++; $display("FAIL bp_drained got=%0d want=8", n); end
    total++;
    if (accepts != 8) begin bad++; $display("FAIL bp_accept_rate got=%0d want=8", accepts); end
    req_valid = 4'h0;
    for (int k = 0; k < LAT + 2; k++) step();
  endtask

  task automatic test_reset_mid;
    do_reset();
    load_table();
    res_ready = 1'b0;
    req_valid = 4'hF;
    for (int k = 0; k < 4; k++) step();
    @(negedge CLK);
    total++;
    if (res_valid !== 1'b1) begin bad++; $display("FAIL mid_full got=%b want=1", res_valid); end
    step();
    reset = 1'b1;
    @(negedge CLK);
    total++;
    if (req_ready !== 4'b0000) begin bad++; $display("FAIL mid_reset_ready got=%b want=0000", req_ready); end
    step();
    reset     = 1'b0;
    res_ready = 1'b1;
    @(negedge CLK);
    total++;
    if (res_valid !== 1'b0) begin bad++; $display("FAIL mid_valid_after got=%b want=0", res_valid); end
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_first_grant got=%b want=0001", req_ready); end
    step();
    req_valid = 4'h0;
    for (int k = 0; k < LAT + 1; k++) step();
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 4'h0;
    res_ready = 1'b1;
    a_v = '0;
    b_v = '0;
    c_v = '0;
    test_reset();
    test_single_req(2, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h6666_6666);
    test_single_req(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
